// File: rtl/field_cfg_loader.sv
// Raster-order coordinate sequencer for loading an initial Game-of-Life field.
// A go request starts one sweep over every (x,y) cell with x varying fastest.
module field_cfg_loader #(
  parameter  int FIELD_W    = 5,
  parameter  int FIELD_H    = 3,
  localparam int X_ADR_SIZE = $clog2(FIELD_W),
  localparam int Y_ADR_SIZE = $clog2(FIELD_H)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_go,
  output logic                  o_is_loading,
  output logic [X_ADR_SIZE-1:0] o_cur_x,
  output logic [Y_ADR_SIZE-1:0] o_cur_y
);

  typedef enum logic {
    IDLE,
    LOAD
  } state_t;

  localparam logic [X_ADR_SIZE-1:0] X_LAST = X_ADR_SIZE'(FIELD_W - 1);
  localparam logic [Y_ADR_SIZE-1:0] Y_LAST = Y_ADR_SIZE'(FIELD_H - 1);

  state_t state;

  // Go is only looked at in IDLE, so a sweep can never be extended or restarted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      o_is_loading <= 1'b0;
      o_cur_x      <= '0;
      o_cur_y      <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_cur_x <= '0;
          o_cur_y <= '0;
          if (i_go) begin
            state        <= LOAD;
            o_is_loading <= 1'b1;
          end else begin
            o_is_loading <= 1'b0;
          end
        end
        LOAD: begin
          if (o_cur_x != X_LAST) begin
            o_cur_x <= o_cur_x + X_ADR_SIZE'(1);
          end else if (o_cur_y != Y_LAST) begin
            o_cur_x <= '0;
            o_cur_y <= o_cur_y + Y_ADR_SIZE'(1);
          end else begin
            state        <= IDLE;
            o_is_loading <= 1'b0;
            o_cur_x      <= '0;
            o_cur_y      <= '0;
          end
        end
        default: begin
          state        <= IDLE;
          o_is_loading <= 1'b0;
          o_cur_x      <= '0;
          o_cur_y      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_field_cfg_loader.sv
// Self-checking bench for field_cfg_loader: a 5x3 instance driven from a vector
// table and directed sequences, plus a 2x2 instance for the minimum field size.
module tb_field_cfg_loader;

  logic       clk;
  logic       rst_n;
  logic       go_a;
  logic       go_b;
  logic       loading_a;
  logic [2:0] x_a;
  logic [1:0] y_a;
  logic       loading_b;
  logic [0:0] x_b;
  logic [0:0] y_b;

  int checks;
  int errors;

  field_cfg_loader #(.FIELD_W(5), .FIELD_H(3)) dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_go         (go_a),
    .o_is_loading (loading_a),
    .o_cur_x      (x_a),
    .o_cur_y      (y_a)
  );

  field_cfg_loader #(.FIELD_W(2), .FIELD_H(2)) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_go         (go_b),
    .o_is_loading (loading_b),
    .o_cur_x      (x_b),
    .o_cur_y      (y_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic go;
    logic loading;
    int   x;
    int   y;
  } vec_t;

  vec_t vecs [17];

  task automatic checkOutput(input string name, input bit use_b,
                             input logic exp_loading, input int exp_x, input int exp_y);
    logic act_loading;
    int   act_x;
    int   act_y;
    act_loading = use_b ? loading_b : loading_a;
    act_x       = use_b ? int'(x_b) : int'(x_a);
    act_y       = use_b ? int'(y_b) : int'(y_a);
    checks++;
    if (act_loading !== exp_loading || act_x != exp_x || act_y != exp_y) begin
      errors++;
      $display("[TB] FAIL %s: got loading=%0d x=%0d y=%0d, expected loading=%0d x=%0d y=%0d",
               name, act_loading, act_x, act_y, exp_loading, exp_x, exp_y);
    end
  endtask

  // One clock cycle: drive go at the falling edge, sample just after the rising edge.
  task automatic applyStimulus(input bit use_b, input logic go);
    @(negedge clk);
    if (use_b) go_b = go;
    else       go_a = go;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input bit use_b, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      applyStimulus(use_b, 1'b0);
      checkOutput($sformatf("%s idle %0d", tag, i), use_b, 1'b0, 0, 0);
    end
  endtask

  // Sweep cycle k=0 is the go edge; go is also held from hold_from onward.
  task automatic runSweep(input bit use_b, input int w, input int h,
                          input int hold_from, input int last_k, input string tag);
    for (int k = 0; k <= last_k; k++) begin
      applyStimulus(use_b, (k == 0) || (k >= hold_from));
      if (k < w * h)
        checkOutput($sformatf("%s k=%0d", tag, k), use_b, 1'b1, k % w, k / w);
      else
        checkOutput($sformatf("%s end", tag), use_b, 1'b0, 0, 0);
    end
    if (use_b) go_b = 1'b0;
    else       go_a = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    go_a   = 1'b0;
    go_b   = 1'b0;

    vecs[0] = '{go: 1'b1, loading: 1'b1, x: 0, y: 0};
    for (int k = 1; k < 15; k++)
      vecs[k] = '{go: 1'b0, loading: 1'b1, x: k % 5, y: k / 5};
    vecs[15] = '{go: 1'b0, loading: 1'b0, x: 0, y: 0};
    vecs[16] = '{go: 1'b0, loading: 1'b0, x: 0, y: 0};

    #3 rst_n = 1'b0;
    #1;
    checkOutput("reset A", 1'b0, 1'b0, 0, 0);
    checkOutput("reset B", 1'b1, 1'b0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    idleCycles(1'b0, 2, "pre");

    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b0, vecs[i].go);
      checkOutput($sformatf("table %0d", i), 1'b0, vecs[i].loading, vecs[i].x, vecs[i].y);
    end
    go_a = 1'b0;

    for (int s = 0; s < 3; s++) begin
      idleCycles(1'b0, $urandom_range(10, 1), $sformatf("gap%0d", s));
      runSweep(1'b0, 5, 3, 99, 15, $sformatf("repeat%0d", s));
    end

    idleCycles(1'b0, 2, "prehold");
    runSweep(1'b0, 5, 3, 3, 15, "held");
    runSweep(1'b0, 5, 3, 99, 15, "afterheld");

    idleCycles(1'b0, 2, "premid");
    runSweep(1'b0, 5, 3, 99, 7, "midreset");
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset async", 1'b0, 1'b0, 0, 0);
    @(posedge clk);
    #1;
    checkOutput("midreset held", 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idleCycles(1'b0, 4, "postreset");
    runSweep(1'b0, 5, 3, 99, 15, "postreset sweep");

    checkOutput("B idle", 1'b1, 1'b0, 0, 0);
    runSweep(1'b1, 2, 2, 99, 4, "small");
    idleCycles(1'b1, 2, "small");
    runSweep(1'b1, 2, 2, 2, 4, "smallheld");
    runSweep(1'b1, 2, 2, 99, 4, "smallagain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
